// File: rtl/alu32_seq.sv
// ============================================================================
// alu32_seq : 32-bit ALU with valid/ready handshake, serial or barrel shifter
// Optional {N,Z,C,V} flags output when ALU32_SEQ_FLAGS_EN is defined. Rev 1.0
// ============================================================================
`default_nettype none

module alu32_seq #(
    parameter int BARREL = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [2:0]  in_op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_r,
    output logic        busy
`ifdef ALU32_SEQ_FLAGS_EN
    ,
    output logic [3:0]  out_flags
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SRA = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;

    state_t      state;
    logic [31:0] work;
    logic [2:0]  op_q;
    logic [4:0]  cnt;

    logic [31:0] imm_res;
    logic [31:0] step_res;
    logic        serial_shift;

`ifdef ALU32_SEQ_FLAGS_EN
    logic [32:0] add_sum;
    logic [32:0] sub_sum;
    logic        imm_c;
    logic        imm_v;

    // Subtraction as A + ~B + 1 so bit 32 is the borrow-not carry.
    assign add_sum = {1'b0, in_a} + {1'b0, in_b};
    assign sub_sum = {1'b0, in_a} + {1'b0, ~in_b} + 33'd1;

    always_comb begin
        imm_c = 1'b0;
        imm_v = 1'b0;
        if (in_op == OP_ADD) begin
            imm_c = add_sum[32];
            imm_v = (in_a[31] == in_b[31]) && (add_sum[31] != in_a[31]);
        end else if (in_op == OP_SUB) begin
            imm_c = sub_sum[32];
            imm_v = (in_a[31] != in_b[31]) && (sub_sum[31] != in_a[31]);
        end
    end
`else
    logic [31:0] add_sum;
    logic [31:0] sub_sum;

    assign add_sum = in_a + in_b;
    assign sub_sum = in_a - in_b;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // Zero-amount shifts and barrel mode finish in the acceptance cycle.
    assign serial_shift = (in_op >= OP_SRA) && (BARREL == 0) && (in_b[4:0] != 5'd0);

    always_comb begin
        case (in_op)
            OP_ADD:  imm_res = add_sum[31:0];
            OP_SUB:  imm_res = sub_sum[31:0];
            OP_AND:  imm_res = in_a & in_b;
            OP_OR:   imm_res = in_a | in_b;
            OP_XOR:  imm_res = in_a ^ in_b;
            OP_SRA:  imm_res = $unsigned($signed(in_a) >>> in_b[4:0]);
            OP_SRL:  imm_res = in_a >> in_b[4:0];
            default: imm_res = in_a << in_b[4:0];
        endcase
    end

    always_comb begin
        case (op_q)
            OP_SRA:  step_res = {work[31], work[31:1]};
            OP_SRL:  step_res = {1'b0, work[31:1]};
            default: step_res = {work[30:0], 1'b0};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            work  <= 32'd0;
            op_q  <= OP_ADD;
            cnt   <= 5'd0;
            out_r <= 32'd0;
`ifdef ALU32_SEQ_FLAGS_EN
            out_flags <= 4'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work <= in_a;
                        op_q <= in_op;
                        cnt  <= in_b[4:0];
                        if (serial_shift) begin
                            state <= SHIFT;
                        end else begin
                            state <= DONE;
                            out_r <= imm_res;
`ifdef ALU32_SEQ_FLAGS_EN
                            out_flags <= {imm_res[31], imm_res == 32'd0, imm_c, imm_v};
`endif
                        end
                    end
                end
                SHIFT: begin
                    work <= step_res;
                    cnt  <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        state <= DONE;
                        out_r <= step_res;
`ifdef ALU32_SEQ_FLAGS_EN
                        out_flags <= {step_res[31], step_res == 32'd0, 2'b00};
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu32_seq.sv
// ============================================================================
// tb_alu32_seq : scoreboard bench for alu32_seq (directed + random commands)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu32_seq;

    localparam int BARREL_TB = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = 32'd0;
    logic [31:0] in_b = 32'd0;
    logic [2:0]  in_op = 3'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_r;
    logic        busy;
`ifdef ALU32_SEQ_FLAGS_EN
    logic [3:0]  out_flags;
`endif

    alu32_seq #(.BARREL(BARREL_TB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .busy      (busy)
`ifdef ALU32_SEQ_FLAGS_EN
        ,
        .out_flags (out_flags)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r;
        logic [3:0]  f;
        int          lat;
        int          c0;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          hs_cyc = 0;
    int          rdy_mode = 0;
    logic        prev_valid = 1'b0;
    logic [31:0] last_r = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: shifts expressed as division/multiplication by 2^k.
    function automatic logic [31:0] model_res(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint unsigned p;
        logic [31:0]     na;
        logic [31:0]     t;
        p  = 64'd1 << b[4:0];
        na = ~a;
        case (op)
            3'd0: t = a + b;
            3'd1: t = a - b;
            3'd2: t = a & b;
            3'd3: t = a | b;
            3'd4: t = a ^ b;
            3'd5: begin
                if (a[31]) begin
                    t = na / p;
                    t = ~t;
                end else begin
                    t = a / p;
                end
            end
            3'd6: t = a / p;
            default: t = a * p;
        endcase
        return t;
    endfunction

    function automatic logic [3:0] model_flags(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] r);
        longint sa, sb, s;
        logic   c, v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c  = 1'b0;
        v  = 1'b0;
        if (op == 3'd0) begin
            c = (longint'(a) + longint'(b)) > 64'sh0FFFFFFFF;
            s = sa + sb;
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else if (op == 3'd1) begin
            c = (a >= b);
            s = sa - sb;
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        return {r[31], r == 32'd0, c, v};
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] b);
        if (op >= 3'd5 && BARREL_TB == 0 && b[4:0] != 5'd0) return int'(b[4:0]) + 1;
        return 1;
    endfunction

    // Call between clock edges; returns just after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic [3:0] ef, output int c0);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        while (!in_ready && guard < 400) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            c0 = -1;
            return;
        end
        @(posedge clk);
        #1;
        c0 = cyc;
        q.push_back('{r: er, f: ef, lat: exp_lat(op, b), c0: cyc});
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        in_op    = 3'($urandom);
    endtask

    task automatic issue_m(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        int          c;
        r = model_res(op, a, b);
        issue(op, a, b, r, model_flags(op, a, b, r), c);
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: checks handshake state every cycle and pops on consumption.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            last_r     = 32'd0;
        end else begin
            if (q.size() == 0) begin
                chk("spurious_valid", out_valid, 0);
                chk("idle_in_ready", in_ready, 1);
                chk("idle_busy", busy, 0);
                chk("hold_out_r", out_r, last_r);
            end else begin
                chk("inflight_in_ready", in_ready, 0);
                chk("inflight_busy", busy, 1);
                if (out_valid) begin
                    if (!prev_valid) chk("latency", cyc - q[0].c0 + 1, q[0].lat);
                    chk("result", out_r, q[0].r);
`ifdef ALU32_SEQ_FLAGS_EN
                    chk("flags", out_flags, q[0].f);
`endif
                    if (out_ready) begin
                        last_r = q[0].r;
                        hs_cyc = cyc + 1;
                        void'(q.pop_front());
                    end
                end else begin
                    chk("hold_out_r", out_r, last_r);
                end
            end
            prev_valid = out_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, rel_cyc;
        logic [2:0]  op;
        logic [31:0] a, b;

        #3;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_r", out_r, 0);
        chk("reset_busy", busy, 0);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("post_reset_in_ready", in_ready, 1);
        rel_cyc = cyc;

        issue(3'b000, 32'd128, 32'd2, 32'd130, model_flags(3'b000, 128, 2, 130), c0);
        chk("first_accept_edge", c0, rel_cyc + 1);
        issue(3'b001, 32'd0, 32'd1, 32'hFFFF_FFFF, 4'b1000, c0);
        issue(3'b010, 32'd127, 32'd2, 32'd2, 4'b0000, c0);
        issue(3'b011, 32'd128, 32'd2, 32'd130, 4'b0000, c0);
        issue(3'b100, 32'd6, 32'd10, 32'd12, 4'b0000, c0);
        issue(3'b101, 32'h8000_000F, 32'd2, 32'hE000_0003, 4'b1000, c0);
        issue(3'b110, 32'h8000_000F, 32'd2, 32'h2000_0003, 4'b0000, c0);
        issue(3'b111, 32'h8000_000F, 32'd2, 32'h0000_003C, 4'b0000, c0);
        issue(3'b111, 32'h1234_5678, 32'hFFFF_FFE0, 32'h1234_5678, 4'b0000, c0);
        issue(3'b101, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 4'b1000, c0);
        issue(3'b000, 32'hFFFF_FFFF, 32'd1, 32'd0, model_flags(3'b000, 32'hFFFF_FFFF, 1, 0), c0);
        issue(3'b000, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000,
              model_flags(3'b000, 32'h7FFF_FFFF, 1, 32'h8000_0000), c0);

        // Backpressure: result held 5+ cycles, second command waits for handshake.
        rdy_mode = 2;
        issue(3'b000, 32'd5, 32'd7, 32'd12, 4'b0000, c0);
        fork
            begin : release_ready
                int g;
                g = 0;
                while (!out_valid && g < 100) begin
                    @(negedge clk);
                    g++;
                end
                repeat (5) @(negedge clk);
                rdy_mode = 0;
            end
            issue(3'b100, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 4'b0000, c1);
        join
        chk("accept_after_handshake", c1, hs_cyc + 1);

        // Reset in the middle of a long shift.
        issue(3'b111, 32'hDEAD_BEEF, 32'd31, 32'h8000_0000, 4'b1000, c0);
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("midshift_reset_out_valid", out_valid, 0);
        chk("midshift_reset_out_r", out_r, 0);
        chk("midshift_reset_busy", busy, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("midshift_reset_in_ready", in_ready, 1);
        repeat (40) @(negedge clk);
        #1;
        issue(3'b111, 32'h0000_0001, 32'd4, 32'h0000_0010, 4'b0000, c0);

        rdy_mode = 1;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
            issue_m(op, a, b);
            if ($urandom_range(0, 3) == 0) begin
                repeat (2) @(posedge clk);
                #1;
            end
        end

        begin : drain
            int g;
            g = 0;
            while (q.size() > 0 && g < 2000) begin
                @(negedge clk);
                g++;
            end
            chk("drain_queue_empty", q.size(), 0);
        end
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu32_seq.md
ALU32_SEQ -- requirements
Module: alu32_seq

Interface
REQ-001 The block SHALL have parameter BARREL, default 0, meaning 0 = shift one bit per cycle and 1 = complete any shift in one step.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: a command is presented.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts a command this cycle.
REQ-006 The block SHALL have port in_a, input, 32 bits: operand A.
REQ-007 The block SHALL have port in_b, input, 32 bits: operand B; bits [4:0] are the shift amount for shift ops.
REQ-008 The block SHALL have port in_op, input, 3 bits: opcode, encoded 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 sra, 110 srl, 111 sll.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 The block SHALL have port out_r, output, 32 bits: the result.
REQ-012 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-013 The block SHALL implement a state machine with states IDLE, SHIFT and DONE.
REQ-014 in_ready SHALL equal 1 only in IDLE; a command SHALL be accepted when in_valid and in_ready are both high at a clock edge.
REQ-015 On acceptance, operands and opcode SHALL be registered, and later changes on the in_* ports SHALL be ignored.
REQ-016 For ops 000-100, the result SHALL be computed on acceptance and the state SHALL go to DONE, so out_valid is high in the next cycle (latency 1).
REQ-017 Add and sub SHALL be modulo 2^32 (two's complement wrap-around), with no saturation.
REQ-018 For shift ops with BARREL=0 and amount k>0, the state SHALL go to SHIFT and move one bit per cycle, then go to DONE, so out_valid rises k+1 cycles after acceptance.
REQ-019 For shift ops with amount k=0, or with BARREL=1, the state SHALL go directly to DONE (latency 1), with out_r = A for k=0.
REQ-020 sra SHALL fill vacated bits with A[31]; srl and sll SHALL fill them with 0; only in_b[4:0] SHALL be used.
REQ-021 In DONE, out_valid SHALL be 1 and out_r SHALL be held stable until out_ready is sampled high; the state SHALL then return to IDLE.
REQ-022 No new command SHALL be accepted in the cycle the result is consumed; in_ready SHALL rise the following cycle.
REQ-023 out_ready asserted while out_valid=0 SHALL have no effect.
REQ-024 out_r SHALL keep its last value while not in DONE.

Reset
REQ-025 Asserting rst_n low SHALL immediately force state IDLE, in_ready=1 (once rst_n is released), out_valid=0, out_r=0, busy=0 and shift counter=0.
REQ-026 Reset asserted during SHIFT or DONE SHALL abort the operation and discard the result; no out_valid SHALL follow.
REQ-027 The first command SHALL be accepted on the first rising edge after rst_n is deasserted.

Configuration
REQ-028 With macro ALU32_SEQ_FLAGS_EN defined, the block SHALL add output out_flags (4 bits, {N,Z,C,V}), valid with out_valid and reset to 0.
REQ-029 Under ALU32_SEQ_FLAGS_EN, C SHALL be the add carry-out or the sub borrow-not, V SHALL be signed overflow for add/sub, and C and V SHALL be 0 for other ops.
REQ-030 Without ALU32_SEQ_FLAGS_EN, the out_flags port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Add: op=000, A=128, B=2, out_ready=1 -> out_r=130 one cycle after acceptance; in_ready high again 2 cycles after acceptance.
REQ-032 Sub wrap: op=001, A=0, B=1 -> out_r=0xFFFFFFFF; with flags enabled, N=1, Z=0, C=0, V=0.
REQ-033 Logic: op=010 with A=127, B=2 -> 2; op=011 with A=128, B=2 -> 130; op=100 with A=6, B=10 -> 12.
REQ-034 Shifts (BARREL=0), A=0x8000000F, B=2: sra -> 0xE0000003, srl -> 0x20000003, sll -> 0x0000003C; out_valid exactly 3 cycles after acceptance; busy high throughout.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_r stable, in_ready=0, and a second in_valid is not accepted until 1 cycle after the out_ready handshake.
REQ-036 Reset mid-shift: sll with B=31, rst_n pulsed low at cycle 10 -> outputs at reset values immediately, no out_valid, and the next command processes correctly.
